// File: rtl/pulse_restore.sv
// Receive side of a stretched-pulse event link: synchronizes 'in', qualifies
// each high run against a minimum width, and emits one single-cycle 'out' per run.
module pulse_restore #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_CYCLES  = 3,
    parameter int MAX_CYCLES  = 64,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in,
    input  logic          clear,
    output logic          out,
    output logic          busy,
    output logic          stuck,
    output logic [CW-1:0] count
);

    localparam int WW = $clog2(MAX_CYCLES + 2);
    localparam logic [WW-1:0] MIN_W = WW'(MIN_CYCLES);
    localparam logic [WW-1:0] SAT_W = WW'(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        ACTIVE,
        STUCK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [WW-1:0]          wcnt_q, wcnt_d, wcnt_inc;
    logic [CW-1:0]          count_q, count_d;
    logic                   out_q, out_d;
    logic                   stuck_q, stuck_d;
    logic                   fire, stuck_set;
    logic                   s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign s        = sync_q[SYNC_STAGES-1];
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], in};
    assign wcnt_inc = (wcnt_q == SAT_W) ? wcnt_q : wcnt_q + WW'(1);

    // Width qualification: the run length is judged on the incremented count
    // so fire and stuck land on the sample that completes the threshold.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = s ? wcnt_inc : '0;
        fire      = 1'b0;
        stuck_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    wcnt_d = WW'(1);
                    if (MIN_CYCLES == 1) begin
                        fire    = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        state_d = QUAL;
                    end
                end
            end
            QUAL: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (wcnt_inc == MIN_W) begin
                    fire    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (wcnt_inc == SAT_W) begin
                    stuck_set = 1'b1;
                    state_d   = STUCK;
                end
            end
            STUCK: begin
                if (!s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear coinciding with a fire keeps that event; a stuck set beats clear.
    always_comb begin
        out_d   = fire;
        stuck_d = stuck_set | (stuck_q & ~clear);
        count_d = count_q;
        if (clear) begin
            count_d = fire ? CW'(1) : '0;
        end else if (fire) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            sync_q  <= '0;
            wcnt_q  <= '0;
            out_q   <= 1'b0;
            stuck_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            wcnt_q  <= wcnt_d;
            out_q   <= out_d;
            stuck_q <= stuck_d;
            count_q <= count_d;
        end
    end

    assign out   = out_q;
    assign busy  = (state_q != IDLE);
    assign stuck = stuck_q;
    assign count = count_q;

endmodule
